// File: rtl/fp16_dot_ctrl.sv
// -----------------------------------------------------------------------------
// fp16_dot_ctrl
//
// Dot-product sequencer acting as the initiator for an external FP16
// multiply-accumulate (MAC) unit. A run is launched with start/len; the block
// clears the MAC for one cycle, streams one operand pair per accepted beat
// into the MAC's A/B inputs (injecting +0 x +0 on idle beats), waits for the
// MAC pipeline to drain and returns the accumulator over a valid/ready port.
// No floating-point arithmetic happens here: out_data is the MAC result
// bit-for-bit.
//
// Parameters
//   LEN_W    width of the vector-length field (max length 2^LEN_W-1)
//   MAC_LAT  clock edges from a change on mac_a/mac_b to the updated
//            accumulator on mac_result
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle run request, sampled only while idle
//   len         in   number of operand pairs, sampled with start
//   in_valid    in   operand pair valid
//   in_a, in_b  in   FP16 operands
//   in_ready    out  operand pair ready (streaming and count below len)
//   mac_a/b     out  registered operands to the MAC
//   mac_reset   out  registered active-low MAC clear
//   mac_result  in   MAC accumulator output
//   out_valid   out  result valid
//   out_data    out  FP16 dot product
//   out_ready   in   result consumer ready
//   busy        out  high in every state except IDLE
//   nan_seen    out  (only with FP16_DOT_NAN_FLAG_EN) a NaN operand was
//                    accepted during the current run
//
// Optional feature macro: FP16_DOT_NAN_FLAG_EN
// -----------------------------------------------------------------------------
module fp16_dot_ctrl #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             in_ready,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_reset,
  input  logic [15:0]      mac_result,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
`ifdef FP16_DOT_NAN_FLAG_EN
  output logic             nan_seen,
`endif
  output logic             busy
);

  // The drain counter must hold MAC_LAT; keep at least one bit so a
  // zero-latency MAC still yields a legal vector.
  localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;      // latched vector length for this run
  logic [LEN_W-1:0]   pair_cnt;   // pairs accepted so far
  logic [DRAIN_W-1:0] drain_cnt;  // remaining drain cycles minus one

  logic             accept;
  logic [LEN_W-1:0] pair_cnt_inc;

  // in_ready is a registered copy of "in STREAM with count below len", so the
  // handshake needs no combinational path from state decode.
  assign accept       = (state == STREAM) && in_valid && in_ready;
  assign pair_cnt_inc = pair_cnt + LEN_W'(1);

`ifdef FP16_DOT_NAN_FLAG_EN
  // FP16 NaN: all-ones exponent with a non-zero mantissa (infinity excluded).
  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction
`endif

  // NOTE: every register below is updated with non-blocking assignments so
  // all state advances together on the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      pair_cnt  <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      mac_a     <= 16'h0000;
      mac_b     <= 16'h0000;
      // Held low while in reset so the MAC is cleared alongside this block.
      mac_reset <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      busy      <= 1'b0;
`ifdef FP16_DOT_NAN_FLAG_EN
      nan_seen  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mac_reset <= 1'b1;
          mac_a     <= 16'h0000;
          mac_b     <= 16'h0000;
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              len_q     <= len;
              pair_cnt  <= '0;
              // Low for exactly the CLEAR cycle; the MAC clears on the edge
              // that leaves CLEAR.
              mac_reset <= 1'b0;
`ifdef FP16_DOT_NAN_FLAG_EN
              nan_seen  <= 1'b0;
`endif
              state     <= CLEAR;
            end else begin
              // Empty vector: the dot product is +0, no MAC traffic needed.
              out_data  <= 16'h0000;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        CLEAR: begin
          mac_reset <= 1'b1;
          mac_a     <= 16'h0000;
          mac_b     <= 16'h0000;
          in_ready  <= 1'b1;
          state     <= STREAM;
        end

        STREAM: begin
          if (accept) begin
            mac_a    <= in_a;
            mac_b    <= in_b;
            pair_cnt <= pair_cnt_inc;
`ifdef FP16_DOT_NAN_FLAG_EN
            if (is_nan(in_a) || is_nan(in_b)) begin
              nan_seen <= 1'b1;
            end
`endif
            // Leaving at equality means pair_cnt can never wrap.
            if (pair_cnt_inc == len_q) begin
              in_ready  <= 1'b0;
              drain_cnt <= DRAIN_W'(MAC_LAT);
              state     <= DRAIN;
            end
          end else begin
            // Bubble: +0 x +0 adds nothing to the running sum.
            mac_a <= 16'h0000;
            mac_b <= 16'h0000;
          end
        end

        DRAIN: begin
          mac_a <= 16'h0000;
          mac_b <= 16'h0000;
          // MAC_LAT+1 cycles in total: the last pair reaches the accumulator
          // MAC_LAT edges after it was driven, and is sampled one edge later.
          if (drain_cnt == '0) begin
            out_data  <= mac_result;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end

        DONE: begin
          // out_data and nan_seen stay frozen until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fp16_dot_ctrl.md
# fp16_dot_ctrl

Dot-product sequencer that acts as the initiator for the FP16 multiply-accumulate unit (MAC). It accepts a vector length and a stream of FP16 operand pairs over a valid/ready handshake, and clears the MAC. It then drives one pair per accepted beat into the MAC's A/B inputs, waits for the MAC pipeline to drain, and returns the accumulated FP16 result over a valid/ready output handshake.

## Interface
- LEN_W, 8: width of the vector-length field; maximum length is 2^LEN_W-1.
- MAC_LAT, 3: clock edges from a change on mac_a/mac_b to the updated accumulator on mac_result.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  one-cycle request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- in_valid  in  1  operand pair valid.
- in_a, in_b  in  16  FP16 operands.
- in_ready  out  1  high only in STREAM while the count is below len.
- mac_a, mac_b  out  16  registered operands driven to the MAC.
- mac_reset  out  1  registered active-low clear to the MAC.
- mac_result  in  16  MAC accumulator output.
- out_valid  out  1  result valid.
- out_data  out  16  FP16 dot product.
- out_ready  in  1  result consumer ready.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - start with len≠0: latch len, clear the pair count, go to CLEAR.
  - start with len=0: load out_data to 16'h0000 and go to DONE.
- CLEAR: lasts one cycle; mac_reset=0 during it; mac_a and mac_b are 0. Go to STREAM.
- STREAM:
  - Each edge with in_valid && in_ready loads mac_a←in_a and mac_b←in_b, and increments the count.
  - Each edge without acceptance loads mac_a and mac_b with 16'h0000. This bubble adds +0×+0 and leaves the sum unchanged.
  - On the edge that accepts pair number len, go to DRAIN.
- DRAIN:
  - Lasts MAC_LAT+1 cycles, timed by a down-counter.
  - mac_a and mac_b are forced to 0 on entry and held at 0.
  - On the exit edge, out_data←mac_result; go to DONE.
- DONE: out_valid=1 and out_data is held stable. On an edge with out_ready=1, go to IDLE.
- start is ignored whenever busy=1. in_valid is ignored outside STREAM.
- No FP arithmetic is performed in this block. out_data is the MAC result bit-for-bit.
- len counter width is LEN_W. The count never wraps, because len is latched and the state exits STREAM at equality.

## Timing
- Reset values:
  - state=IDLE, busy=0, in_ready=0, out_valid=0, out_data=0.
  - mac_a=0, mac_b=0, mac_reset=0, which holds the MAC in clear while this block is in reset.
  - mac_reset rises to 1 on the first edge after reset release.
- Latency:
  - start edge → CLEAR for one cycle → in_ready is high from the 2nd edge after start.
  - Last acceptance edge k → out_valid is high after edge k+MAC_LAT+1 (k+4 at the default).
  - For len=0, out_valid is high one edge after start.
- Throughput: one pair per cycle while in_valid is held high.
- Reset mid-operation (any state): return to IDLE immediately. Any partial result is discarded, and mac_reset drives the MAC clear.
- Back-to-back operation: a start in the cycle after the out_ready handshake is accepted.

## Configuration
- FP16_DOT_NAN_FLAG_EN defined:
  - Adds output nan_seen (1 bit, reset 0).
  - nan_seen is cleared in CLEAR.
  - nan_seen is set on any accepted pair where either operand has exponent 5'h1F and mantissa ≠0.
  - nan_seen is valid alongside out_valid.
- FP16_DOT_NAN_FLAG_EN undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- len=3; pairs (3C00,4000), (4000,4000), (4200,4000) on consecutive cycles → out_data=4A00 (12.0); out_valid appears 4 edges after the 3rd acceptance.
- Same vector with in_valid deasserted for 2 cycles between pairs → out_data=4A00; zero-injection bubbles do not alter the sum.
- Back-to-back runs: a second run with len=1 and pair (3800,4400) → 4000; this confirms CLEAR discards the prior 4A00.
- len=0 start → out_valid after one edge with out_data=0000. Hold out_ready=0 for 5 cycles and pulse start → out_valid and out_data are held, and start is ignored.
- Reset asserted in STREAM after 2 of 4 pairs → all outputs take their reset values immediately, with mac_reset=0. A fresh len=1 run (3C00,3C00) then returns 3C00.
- With FP16_DOT_NAN_FLAG_EN defined: len=2, pairs (7E00,3C00), (3C00,3C00) → nan_seen=1 at out_valid. The next clean run gives nan_seen=0.
